// File: rtl/d20_roll_sampler_if.sv
// Bundles the d20 sampler's pattern-memory read bus and its roll valid/ready
// handshake.
//   mem_addr   : read address driven by the sampler
//   mem_data   : read data, returned one cycle after mem_addr
//   roll       : accepted die value, 1..20
//   roll_valid : roll holds a value that has not been taken yet
//   roll_ready : consumer takes roll when roll_valid && roll_ready
// The master modport is the sampler. The slave modport is the memory
// together with the roll consumer.
interface d20_roll_sampler_if #(
  parameter int RAND_BITS = 5,
  parameter int ADDR_BITS = 8
);
  logic [ADDR_BITS-1:0] mem_addr;
  logic [RAND_BITS-1:0] mem_data;
  logic [RAND_BITS-1:0] roll;
  logic                 roll_valid;
  logic                 roll_ready;

  modport master (
    output mem_addr, roll, roll_valid,
    input  mem_data, roll_ready
  );

  modport slave (
    input  mem_addr, roll, roll_valid,
    output mem_data, roll_ready
  );
endinterface

// File: rtl/d20_roll_sampler.sv
// d20_roll_sampler: walks a bit-pattern memory and turns each RAND_BITS word
// into a uniform 1..20 die value by rejection sampling. A word of 0..19 is
// accepted as value+1. A word of 20 or more is discarded and counted. Each
// accepted value is offered to the consumer over a valid/ready handshake.
// Ports:
//   clk, reset   : clock and synchronous active-high reset
//   en           : allows new memory reads; the sampler pauses in S_REQ when low
//   bus          : d20_roll_sampler_if.master (memory read bus and roll handshake)
//   roll_count   : saturating count of rolls handed off
//   reject_count : saturating count of rejected words
// Optional build macro ADVANTAGE_EN adds the adv_mode input. When adv_mode is
// set at the start of a roll, two accepted values are drawn and the larger
// one is offered as the roll.
module d20_roll_sampler #(
  parameter int RAND_BITS = 5,
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_BITS = $clog2(MEM_DEPTH),
  parameter int CNT_BITS  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
`ifdef ADVANTAGE_EN
  input  logic                adv_mode,
`endif
  d20_roll_sampler_if.master  bus,
  output logic [CNT_BITS-1:0] roll_count,
  output logic [CNT_BITS-1:0] reject_count
);

  typedef enum logic [1:0] {S_REQ, S_EVAL, S_HOLD} state_t;

  localparam logic [RAND_BITS-1:0] MAX_WORD = RAND_BITS'(19);

  state_t               state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [RAND_BITS-1:0] roll_q, roll_d;
  logic                 valid_q, valid_d;
  logic [CNT_BITS-1:0]  roll_cnt_q, roll_cnt_d;
  logic [CNT_BITS-1:0]  rej_cnt_q, rej_cnt_d;
  logic [RAND_BITS-1:0] face;
`ifdef ADVANTAGE_EN
  logic [RAND_BITS-1:0] first_q, first_d;
  logic                 second_q, second_d;  // the next accepted word completes an advantage roll
  logic                 adv_q, adv_d;        // adv_mode captured when the roll started
`endif

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] c);
    return (&c) ? c : c + CNT_BITS'(1);
  endfunction

  // Written as an explicit compare so the wrap also works when MEM_DEPTH is
  // not a power of two.
  function automatic logic [ADDR_BITS-1:0] wrap_inc(input logic [ADDR_BITS-1:0] a);
    return (a == ADDR_BITS'(MEM_DEPTH - 1)) ? '0 : a + ADDR_BITS'(1);
  endfunction

  assign face = bus.mem_data + RAND_BITS'(1);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    roll_d     = roll_q;
    valid_d    = valid_q;
    roll_cnt_d = roll_cnt_q;
    rej_cnt_d  = rej_cnt_q;
`ifdef ADVANTAGE_EN
    first_d    = first_q;
    second_d   = second_q;
    adv_d      = adv_q;
`endif
    case (state_q)
      S_REQ: begin
        if (en) begin
          state_d = S_EVAL;
`ifdef ADVANTAGE_EN
          if (!second_q) adv_d = adv_mode;
`endif
        end
      end
      S_EVAL: begin
        addr_d = wrap_inc(addr_q);
        if (bus.mem_data <= MAX_WORD) begin
`ifdef ADVANTAGE_EN
          if (adv_q && !second_q) begin
            first_d  = face;
            second_d = 1'b1;
            state_d  = S_REQ;
          end else begin
            roll_d   = (second_q && first_q > face) ? first_q : face;
            second_d = 1'b0;
            valid_d  = 1'b1;
            state_d  = S_HOLD;
          end
`else
          roll_d  = face;
          valid_d = 1'b1;
          state_d = S_HOLD;
`endif
        end else begin
          rej_cnt_d = sat_inc(rej_cnt_q);
          state_d   = S_REQ;
        end
      end
      S_HOLD: begin
        if (bus.roll_ready) begin
          valid_d    = 1'b0;
          roll_cnt_d = sat_inc(roll_cnt_q);
          state_d    = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_REQ;
      addr_q     <= '0;
      roll_q     <= '0;
      valid_q    <= 1'b0;
      roll_cnt_q <= '0;
      rej_cnt_q  <= '0;
`ifdef ADVANTAGE_EN
      first_q    <= '0;
      second_q   <= 1'b0;
      adv_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      roll_q     <= roll_d;
      valid_q    <= valid_d;
      roll_cnt_q <= roll_cnt_d;
      rej_cnt_q  <= rej_cnt_d;
`ifdef ADVANTAGE_EN
      first_q    <= first_d;
      second_q   <= second_d;
      adv_q      <= adv_d;
`endif
    end
  end

  assign bus.mem_addr   = addr_q;
  assign bus.roll       = roll_q;
  assign bus.roll_valid = valid_q;
  assign roll_count     = roll_cnt_q;
  assign reject_count   = rej_cnt_q;

endmodule

// File: tb/tb_d20_roll_sampler.sv
// Self-checking bench for d20_roll_sampler in its default build. A small
// pattern memory and narrow counters are used so that address wrap and
// counter saturation are reached quickly. Expected rolls come from a
// transaction-level model that scans the memory contents directly.
module tb_d20_roll_sampler;
  localparam int RB    = 5;
  localparam int DEPTH = 8;
  localparam int AB    = 3;
  localparam int CB    = 4;
  localparam int CMAX  = (1 << CB) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          en = 1'b0;
  logic [CB-1:0] roll_count;
  logic [CB-1:0] reject_count;

  d20_roll_sampler_if #(.RAND_BITS(RB), .ADDR_BITS(AB)) bus ();

  d20_roll_sampler #(
    .RAND_BITS(RB), .MEM_DEPTH(DEPTH), .ADDR_BITS(AB), .CNT_BITS(CB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .bus(bus.master),
    .roll_count(roll_count),
    .reject_count(reject_count)
  );

  always #5 clk = ~clk;

  logic [RB-1:0] mem [DEPTH];
  always @(posedge clk) bus.mem_data <= mem[bus.mem_addr];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference model state
  int m_ptr, m_rolls, m_rej;
  logic prev_v, prev_r;
  int prev_roll, prev_addr;

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_rolls = 0; m_rej = 0;
    prev_v = 1'b0; prev_r = 1'b0; prev_roll = 0; prev_addr = 0;
  endtask

  // Scan forward from the model pointer to the next accepted word.
  task automatic model_next(output int val);
    val = -1;
    for (int k = 0; k < 4 * DEPTH && val < 0; k++) begin
      if (mem[m_ptr] >= 20) m_rej++;
      else val = mem[m_ptr] + 1;
      m_ptr = (m_ptr + 1) % DEPTH;
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(negedge clk);
    check("rst_roll_valid", bus.roll_valid, 0);
    check("rst_roll", bus.roll, 0);
    check("rst_roll_count", roll_count, 0);
    check("rst_reject_count", reject_count, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    model_reset();
  endtask

  task automatic release_and_time(input int exp_cycles);
    int cyc;
    reset = 1'b0; en = 1'b1; bus.roll_ready = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.roll_valid && cyc < 100);
    check("first_valid_latency", cyc, exp_cycles);
  endtask

  task automatic run(input int cycles, input int p_en, input int p_rdy);
    int v;
    for (int i = 0; i < cycles; i++) begin
      en = ($urandom_range(0, 99) < p_en);
      bus.roll_ready = ($urandom_range(0, 99) < p_rdy);
      if (prev_v && !prev_r) begin
        check("hold_valid", bus.roll_valid, 1);
        check("hold_roll", bus.roll, prev_roll);
        check("hold_addr", bus.mem_addr, prev_addr);
      end
      if (prev_v && prev_r) begin
        check("post_handoff_valid", bus.roll_valid, 0);
        check("post_handoff_count", roll_count, sat(m_rolls));
      end
      if (bus.roll_valid && bus.roll_ready) begin
        model_next(v);
        check("roll_value", bus.roll, v);
        check("roll_in_range", int'(bus.roll >= 1 && bus.roll <= 20), 1);
        check("reject_count", reject_count, sat(m_rej));
        check("addr_at_handoff", bus.mem_addr, m_ptr);
        check("count_before_handoff", roll_count, sat(m_rolls));
        m_rolls++;
      end
      prev_v = bus.roll_valid; prev_r = bus.roll_ready;
      prev_roll = bus.roll; prev_addr = bus.mem_addr;
      @(negedge clk);
    end
  endtask

  initial begin
    bus.roll_ready = 1'b0;
    model_reset();
    @(negedge clk);

    // Rolls 4, 20, 1 first; back-to-back throughput
    for (int i = 0; i < DEPTH; i++) mem[i] = RB'($urandom_range(0, 31));
    mem[0] = 5'd3; mem[1] = 5'd19; mem[2] = 5'd0;
    apply_reset();
    release_and_time(2);
    run(40, 100, 100);

    // Three rejects before the first accept
    reset = 1'b1;
    mem[0] = 5'd25; mem[1] = 5'd31; mem[2] = 5'd20; mem[3] = 5'd7;
    apply_reset();
    release_and_time(8);
    run(60, 70, 50);

    // Consumer stalls for 10 cycles, then takes the roll
    reset = 1'b1;
    mem[0] = 5'd12;
    apply_reset();
    release_and_time(2);
    run(10, 100, 0);
    run(1, 100, 100);
    run(3, 100, 0);

    // Address wrap over the whole memory
    reset = 1'b1;
    for (int i = 0; i < DEPTH; i++) mem[i] = RB'((i % 4) + 1);
    apply_reset();
    release_and_time(2);
    run(60, 100, 100);

    // Long random run drives both counters into saturation
    reset = 1'b1;
    for (int i = 0; i < DEPTH; i++) mem[i] = RB'($urandom_range(0, 31));
    mem[0] = 5'd20; mem[1] = 5'd2;
    apply_reset();
    reset = 1'b0;
    run(500, 80, 60);
    check("sat_roll_count", roll_count, sat(m_rolls));
    check("sat_reject_count", reject_count, sat(m_rej));

    // Reset while a roll is held
    reset = 1'b1;
    mem[0] = 5'd5; mem[1] = 5'd6;
    apply_reset();
    release_and_time(2);
    run(3, 100, 0);
    apply_reset();

    // Reset while evaluating the word that follows a handoff
    release_and_time(2);
    run(1, 100, 100);
    en = 1'b1;
    @(negedge clk);
    apply_reset();

    // Resets dropped at random points of random runs
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = RB'($urandom_range(0, 31));
      apply_reset();
      reset = 1'b0;
      run($urandom_range(5, 60), 75, 60);
    end
    apply_reset();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
